// File: rtl/shift_add_multiplier_module_pkg.sv
// Shared arithmetic package: control-state encoding used by the shift-add
// multiplier and the iterative divider's control wrapper, plus width helpers.
package shift_add_multiplier_module_pkg;

  // Common control encoding. Both the multiplier and the divider wrapper use
  // these exact values, so one control FSM can decode either block's state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arith_state_e;

  // Width of the product of two bits-wide unsigned operands.
  function automatic int product_width(input int bits);
    return 2 * bits;
  endfunction

  // Width of an iteration counter that must reach bits-1. Never returns less
  // than one so a two-bit operand still gets a real counter bit.
  function automatic int count_width(input int bits);
    return (bits > 2) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_module.sv
// Sequential unsigned radix-2 shift-add multiplier.
//
// Handshake: start is sampled on a rising edge only while the block is in
// IDLE or DONE; that edge is the accept. Operands are captured at accept and
// ignored afterwards. ready rises together with a fresh result and is held
// until the next accept or reset; busy is high exactly while iterating, so
// busy and ready are never high together. start during RUN is ignored.
//
// Optional build macro SHIFT_ADD_MUL_EARLY_TERM_EN: when defined, iteration
// stops as soon as the remaining multiplier bits are all zero, giving a
// latency of max(1, index of highest set multiplier bit + 1) edges. Products
// are identical in both builds and the port list does not change.
module shift_add_multiplier_module
  import shift_add_multiplier_module_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BITS-1:0]               multiplicando,
  input  logic [BITS-1:0]               multiplicador,
  output logic [product_width(BITS)-1:0] result,
  output logic                          ready,
  output logic                          busy
);

  localparam int PW = product_width(BITS);
  localparam int CW = count_width(BITS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(BITS - 1);

  // State and datapath registers. state_q is the observable FSM state.
  arith_state_e    state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [BITS-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   result_q, result_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  // Single add/shift step, evaluated every cycle; only used in RUN.
  logic [PW-1:0]   acc_next;
  logic [BITS-1:0] mplier_next;
  logic            last_iter;

  // Combinational datapath step: conditional add of the shifted multiplicand.
  always_comb begin
    acc_next    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_next = mplier_q >> 1;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    // Stop once no set multiplier bits remain; the counter bound still caps
    // the run at BITS iterations.
    last_iter   = (count_q == LAST_COUNT) || (mplier_next == '0);
`else
    last_iter   = (count_q == LAST_COUNT);
`endif
  end

  // Next-state and register-update logic; every target defaults to hold.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;
    ready_d  = ready_q;
    busy_d   = busy_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Accept: capture operands, clear the accumulator, drop ready.
          // result keeps the previous product until the new one is ready.
          mcand_d  = {{(PW - BITS){1'b0}}, multiplicando};
          mplier_d = multiplicador;
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
          state_d  = RUN;
        end
      end

      RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_next;
        count_d  = count_q + 1'b1;
        if (last_iter) begin
          result_d = acc_next;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        busy_d  = 1'b0;
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-high reset clearing everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_shift_add_multiplier_module.sv
// Directed testbench for shift_add_multiplier_module (BITS=16). Honours
// SHIFT_ADD_MUL_EARLY_TERM_EN when it is defined for the whole build.
module tb_shift_add_multiplier_module;

  localparam int BITS = 16;
  localparam int PW   = 2 * BITS;

  logic            clk;
  logic            reset;
  logic            start;
  logic [BITS-1:0] multiplicando;
  logic [BITS-1:0] multiplicador;
  logic [PW-1:0]   result;
  logic            ready;
  logic            busy;

  int total;
  int bad;
  logic [PW-1:0] exp_result;

  shift_add_multiplier_module #(.BITS(BITS)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .result        (result),
    .ready         (ready),
    .busy          (busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected number of edges from accept to ready.
  function automatic int exp_lat(input logic [BITS-1:0] b);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    int l;
    l = 1;
    for (int i = 0; i < BITS; i++) if (b[i]) l = i + 1;
    return l;
`else
    return BITS;
`endif
  endfunction

  // Driver: advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present a request for exactly one edge (the accept edge).
  task automatic drive_start(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    start         = 1'b1;
    multiplicando = a;
    multiplicador = b;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    step();
    step();
    total++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL reset: ready=%b busy=%b result=%h, need 0 0 0", ready, busy, result);
    end
    reset = 1'b0;
    step();
    total++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: ready=%b busy=%b, need 0 0", ready, busy);
    end
    exp_result = '0;
  endtask

  // One full product: checks accept edge, every iteration, completion, hold.
  task automatic test_product(input string name, input logic [BITS-1:0] a,
                              input logic [BITS-1:0] b);
    logic [PW-1:0] prod;
    int lat;
    prod = PW'(a) * PW'(b);
    lat  = exp_lat(b);
    drive_start(a, b);
    total++;
    if (busy !== 1'b1 || ready !== 1'b0 || result !== exp_result) begin
      bad++;
      $display("FAIL %s_accept: busy=%b ready=%b result=%h, need 1 0 %h",
               name, busy, ready, result, exp_result);
    end
    // Operand changes after accept must not matter.
    multiplicando = BITS'($urandom_range(0, 65535));
    multiplicador = BITS'($urandom_range(0, 65535));
    for (int k = 1; k < lat; k++) begin
      step();
      total++;
      if (busy !== 1'b1 || ready !== 1'b0 || result !== exp_result) begin
        bad++;
        $display("FAIL %s_iter%0d: busy=%b ready=%b result=%h, need 1 0 %h",
                 name, k, busy, ready, result, exp_result);
      end
    end
    step();
    total++;
    if (busy !== 1'b0 || ready !== 1'b1 || result !== prod) begin
      bad++;
      $display("FAIL %s_done: busy=%b ready=%b result=%h, need 0 1 %h",
               name, busy, ready, result, prod);
    end
    exp_result = prod;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (busy !== 1'b0 || ready !== 1'b1 || result !== prod) begin
        bad++;
        $display("FAIL %s_hold%0d: busy=%b ready=%b result=%h, need 0 1 %h",
                 name, k, busy, ready, result, prod);
      end
    end
  endtask

  task automatic test_start_in_run();
    int lat;
    lat = exp_lat(16'd200);
    drive_start(16'd100, 16'd200);
    step();
    step();
    step();
    // Second request during iteration 4 must be ignored.
    start = 1'b1;
    multiplicando = 16'd7;
    multiplicador = 16'd7;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL run_start_ignored: busy=%b ready=%b, need 1 0", busy, ready);
    end
    for (int k = 5; k < lat; k++) step();
    step();
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || result !== 32'd20000) begin
      bad++;
      $display("FAIL run_start_result: ready=%b busy=%b result=%0d, need 1 0 20000",
               ready, busy, result);
    end
    exp_result = 32'd20000;
    // Nothing queued: the block must stay in DONE.
    step();
    step();
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || result !== 32'd20000) begin
      bad++;
      $display("FAIL run_start_no_restart: ready=%b busy=%b result=%0d, need 1 0 20000",
               ready, busy, result);
    end
  endtask

  task automatic test_reset_mid_run();
    int rst_at;
    rst_at = (exp_lat(16'h0056) > 7) ? 7 : exp_lat(16'h0056) - 1;
    drive_start(16'h1234, 16'h0056);
    for (int k = 1; k < rst_at; k++) step();
    reset = 1'b1;
    step();
    total++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL reset_mid_run: ready=%b busy=%b result=%h, need 0 0 0",
               ready, busy, result);
    end
    reset = 1'b0;
    step();
    total++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL reset_mid_run_idle: ready=%b busy=%b result=%h, need 0 0 0",
               ready, busy, result);
    end
    exp_result = '0;
    test_product("after_reset_2x2", 16'd2, 16'd2);
  endtask

  task automatic test_back_to_back();
    test_product("b2b_first_3x5", 16'd3, 16'd5);
    total++;
    if (ready !== 1'b1 || result !== 32'd15) begin
      bad++;
      $display("FAIL b2b_ready_before: ready=%b result=%0d, need 1 15", ready, result);
    end
    // Accept from DONE: ready drops, result keeps 15 until the new product.
    test_product("b2b_second_9x9", 16'd9, 16'd9);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_product("mul_3x5", 16'd3, 16'd5);
    test_product("mul_ffff", 16'hFFFF, 16'hFFFF);
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    test_product("mul_x0", 16'd1234, 16'd0);
    test_product("mul_7x5", 16'd7, 16'd5);
    test_product("mul_1x8000", 16'd1, 16'h8000);
    test_product("mul_0xffff", 16'd0, 16'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
